// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one registered adder among NUM_REQ requesters.
// Optional grant/busy statistics counters are enabled by defining ADDER_ARB_STATS_EN.
module adder_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int ADD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_in1,
    input  logic [NUM_REQ*DATA_W-1:0] req_in2,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W:0]           rsp_data,
    output logic [DATA_W-1:0]         add_in1,
    output logic [DATA_W-1:0]         add_in2,
    input  logic [DATA_W:0]           add_out
`ifdef ADDER_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NUM_REQ*16-1:0]     stat_grant_cnt,
    output logic [15:0]               stat_busy_cnt
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]                  ptr, gnt_id, idx;
    logic                             gnt_any, hs;
    logic [ADD_LATENCY:0]             tag_v;
    logic [ADD_LATENCY:0][ID_W-1:0]   tag_id;

    // Scan downward so the candidate closest to the pointer is assigned last and wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign hs        = gnt_any & ~rst;
    assign req_ready = hs ? NUM_REQ'(1) << gnt_id : '0;
    assign rsp_valid = tag_v[ADD_LATENCY] ? NUM_REQ'(1) << tag_id[ADD_LATENCY] : '0;
    assign rsp_data  = add_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            add_in1 <= '0;
            add_in2 <= '0;
            tag_v   <= '0;
            tag_id  <= '0;
        end else begin
            if (hs) begin
                ptr     <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
                add_in1 <= req_in1[int'(gnt_id)*DATA_W +: DATA_W];
                add_in2 <= req_in2[int'(gnt_id)*DATA_W +: DATA_W];
            end
            tag_v[0]  <= hs;
            tag_id[0] <= gnt_id;
            for (int k = 1; k <= ADD_LATENCY; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grant_cnt <= '0;
            stat_busy_cnt  <= '0;
        end else if (stat_clr) begin
            stat_grant_cnt <= '0;
            stat_busy_cnt  <= '0;
        end else if (hs) begin
            if (stat_busy_cnt != 16'hFFFF)
                stat_busy_cnt <= stat_busy_cnt + 16'd1;
            if (stat_grant_cnt[int'(gnt_id)*16 +: 16] != 16'hFFFF)
                stat_grant_cnt[int'(gnt_id)*16 +: 16] <= stat_grant_cnt[int'(gnt_id)*16 +: 16] + 16'd1;
        end
    end
`endif
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
Shares one registered adder instance (simpleAdder-style: in1/in2 sampled on clk, sum on out) between NUM_REQ requesters.
- Round-robin arbitration, one operation issued per cycle.
- Registers operands toward the adder and tracks requester IDs through the adder latency.
- Returns each sum to its originating requester as a one-cycle response pulse.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, operand width; sum width is DATA_W+1
ADD_LATENCY, 1, clock cycles from adder input sample to valid adder output

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset (async assert, release synchronous to clk)
req_valid  in  NUM_REQ  per-requester operation request
req_ready  out  NUM_REQ  per-requester grant; handshake when valid&ready
req_in1  in  NUM_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
req_in2  in  NUM_REQ*DATA_W  packed operand B, same packing
rsp_valid  out  NUM_REQ  one-hot pulse: sum for requester i is on rsp_data
rsp_data  out  DATA_W+1  sum returned from the adder
add_in1  out  DATA_W  registered operand A to the shared adder
add_in2  out  DATA_W  registered operand B to the shared adder
add_out  in  DATA_W+1  shared adder result

Behaviour:
- Reset values:
  - add_in1 = 0, add_in2 = 0.
  - rsp_valid = 0, req_ready = 0.
  - Round-robin pointer = 0; tag pipeline cleared.
- Arbitration (combinational, cycle T):
  - Grant the first i with req_valid[i] = 1, scanning from pointer upward, modulo NUM_REQ.
  - req_ready is one-hot or zero; req_ready[i] = 1 only if req_valid[i] = 1.
  - No grant in any cycle where rst = 1.
- Pointer update: on a grant to i, pointer <= (i+1) mod NUM_REQ. With no grant, pointer holds.
- Requester rules: hold req_valid and operands stable until the handshake. Dropping valid before the handshake withdraws the request; that is legal.
- Issue:
  - On a handshake in cycle T, add_in1/add_in2 <= selected operands at the end of T.
  - In cycles with no grant, add_in1/add_in2 hold their previous values. This is required: no input toggling on idle cycles.
- Tag pipeline:
  - Depth ADD_LATENCY+1, entries {valid, id}.
  - Stage 0 is loaded with the handshake; each stage shifts every cycle.
- Response:
  - An op accepted in cycle T returns in cycle T+ADD_LATENCY+1 (T+2 at default).
  - rsp_valid[id] = 1 for exactly one cycle.
  - rsp_data = add_out, combinational passthrough.
  - When no response is valid, rsp_data is don't-care and rsp_valid = 0.
- Throughput: one op per cycle sustained, back-to-back. Responses return in issue order.
- No response back-pressure: requesters must accept rsp_valid in the cycle it is asserted.
- Arithmetic: full DATA_W+1 result; no truncation, no wrap.
- Reset mid-operation:
  - All in-flight tags are discarded.
  - No rsp_valid for any op accepted before rst asserted, including after rst deasserts.
- Single requester: it is granted every cycle it is valid; the pointer walks accordingly and no starvation is possible.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,... No requester waits more than NUM_REQ-1 cycles.

Optional Feature:
Macro ADDER_ARB_STATS_EN.
- Defined:
  - Adds output stat_grant_cnt (NUM_REQ*16 bits): per-requester 16-bit saturating grant counters, saturating at 0xFFFF.
  - Adds output stat_busy_cnt (16 bits): saturating count of cycles with a grant.
  - Adds input stat_clr: synchronous clear of all counters; clear wins over a same-cycle increment.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single-op path: rst pulse, then requester 0 issues in1 = 0xA5, in2 = 0xA5 in cycle T.
  - Response: rsp_valid = 4'b0001 and rsp_data = 0x14A in cycle T+2.
  - No other rsp_valid pulses.
- Full contention: all four requesters valid with in1 = in2 = 0x0F, 0x8F, 0x0B, 0x33 (requesters 0..3).
  - Grants in order 0,1,2,3.
  - Responses 0x01E, 0x11E, 0x016, 0x066 on consecutive cycles, one-hot ids matching.
- Round-robin wrap: requesters 1 and 3 always valid, pointer at 2.
  - Grants 3,1,3,1.
  - req_ready is never set for a non-valid requester.
- Idle hold: after one issue with 0x0F+0x0F, no requests for 10 cycles.
  - add_in1/add_in2 stay 0x0F with zero toggles.
  - rsp_valid stays 0 after the single response.
- Reset mid-flight: handshake in cycle T, rst asserted in cycle T+1 for 3 cycles.
  - No rsp_valid ever for that op.
  - add_in* = 0 and pointer = 0 after reset.
- Stats (ADDER_ARB_STATS_EN): 5 grants to requester 2 give stat_grant_cnt[2] = 5 and stat_busy_cnt = 5.
  - stat_clr asserted in the same cycle as a grant gives 0.
